r_operand_stage: RTL

//  Decode/operand stage directly upstream of the R-type ALU.

---
 rtl/r_operand_stage_if.sv | 29 ++
 rtl/r_operand_stage.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/r_operand_stage_if.sv
// Handshake, writeback and operand bundle between the fetch side, the writeback stage
// and the R-type ALU, with r_operand_stage on the slave side.
interface r_operand_stage_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr_in;
    logic              wb_en;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       inst_reg;
    logic [DATA_W-1:0] ALU_I1;
    logic [DATA_W-1:0] ALU_I2;
    logic [4:0]        shift;
    logic              illegal;

    modport master (
        output in_valid, instr_in, wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, inst_reg, ALU_I1, ALU_I2, shift, illegal
    );

    modport slave (
        input  in_valid, instr_in, wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, inst_reg, ALU_I1, ALU_I2, shift, illegal
    );
endinterface

// File: rtl/r_operand_stage.sv
// Decode/operand stage feeding the R-type ALU: register-file read with writeback
// forwarding, shift-amount select and a one-entry valid/ready output register.
module r_operand_stage #(
    parameter int DATA_W   = 32,
    parameter bit RESET_RF = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    r_operand_stage_if.slave  bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            state_r, state_n;
    logic [31:0]       inst_r;
    logic [DATA_W-1:0] alu_i1_r, alu_i2_r;
    logic [4:0]        shift_r;
    logic              illegal_r, illegal_n;
    logic [DATA_W-1:0] rf_r [32];

    logic              in_ready_s, accept_s, is_rtype_s, load_s, wb_hit_s;
    logic [4:0]        rs_s, rt_s, held_rs_s, held_rt_s, shift_sel_s;
    logic [DATA_W-1:0] rs_val_s, rt_val_s;
    logic              hold_s, refresh_i1_s, refresh_i2_s;

    // sllv/srlv/srav take their shift amount from rs instead of shamt
    function automatic logic is_var_shift(input logic [5:0] funct);
        case (funct)
            6'b000100: is_var_shift = 1'b1;
            6'b000110: is_var_shift = 1'b1;
            6'b000111: is_var_shift = 1'b1;
            default:   is_var_shift = 1'b0;
        endcase
    endfunction

    assign rs_s       = bus.instr_in[25:21];
    assign rt_s       = bus.instr_in[20:16];
    assign held_rs_s  = inst_r[25:21];
    assign held_rt_s  = inst_r[20:16];
    assign wb_hit_s   = bus.wb_en & (bus.wb_addr != 5'd0);
    assign in_ready_s = (state_r == EMPTY) | bus.out_ready;
    assign accept_s   = bus.in_valid & in_ready_s;
    assign is_rtype_s = (bus.instr_in[31:26] == 6'd0);
    assign hold_s     = (state_r == FULL) & ~bus.out_ready;
    assign refresh_i1_s = hold_s & wb_hit_s & (bus.wb_addr == held_rs_s);
    assign refresh_i2_s = hold_s & wb_hit_s & (bus.wb_addr == held_rt_s);

    // Operand read: a same-cycle write wins over the array, R0 always reads zero
    always_comb begin
        rs_val_s = '0;
        rt_val_s = '0;
        if (wb_hit_s && (bus.wb_addr == rs_s)) begin
            rs_val_s = bus.wb_data;
        end else if (rs_s != 5'd0) begin
            rs_val_s = rf_r[rs_s];
        end else begin
            rs_val_s = '0;
        end
        if (wb_hit_s && (bus.wb_addr == rt_s)) begin
            rt_val_s = bus.wb_data;
        end else if (rt_s != 5'd0) begin
            rt_val_s = rf_r[rt_s];
        end else begin
            rt_val_s = '0;
        end
        shift_sel_s = is_var_shift(bus.instr_in[5:0]) ? rs_val_s[4:0] : bus.instr_in[10:6];
    end

    // Next state: a non-R word is swallowed and leaves the stage empty
    always_comb begin
        state_n   = state_r;
        load_s    = 1'b0;
        illegal_n = 1'b0;
        case (state_r)
            EMPTY, FULL: begin
                if (accept_s) begin
                    if (is_rtype_s) begin
                        state_n = FULL;
                        load_s  = 1'b1;
                    end else begin
                        state_n   = EMPTY;
                        illegal_n = 1'b1;
                    end
                end else if (state_r == FULL && bus.out_ready) begin
                    state_n = EMPTY;
                end else begin
                    state_n = state_r;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_n;
        end
    end

    // Output register: load on accept, otherwise refresh a held entry from writeback
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_r    <= 32'd0;
            alu_i1_r  <= '0;
            alu_i2_r  <= '0;
            shift_r   <= 5'd0;
            illegal_r <= 1'b0;
        end else begin
            illegal_r <= illegal_n;
            if (load_s) begin
                inst_r   <= bus.instr_in;
                alu_i1_r <= rs_val_s;
                alu_i2_r <= rt_val_s;
                shift_r  <= shift_sel_s;
            end else begin
                if (refresh_i1_s) alu_i1_r <= bus.wb_data;
                if (refresh_i2_s) alu_i2_r <= bus.wb_data;
                if (refresh_i1_s && is_var_shift(inst_r[5:0])) shift_r <= bus.wb_data[4:0];
            end
        end
    end

    generate
        if (RESET_RF) begin : g_rf_reset
            // Register file with clear-on-reset
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < 32; i++) rf_r[i] <= '0;
                end else if (wb_hit_s) begin
                    rf_r[bus.wb_addr] <= bus.wb_data;
                end
            end
        end else begin : g_rf_noreset
            // Register file without reset
            always_ff @(posedge clk) begin
                if (wb_hit_s) begin
                    rf_r[bus.wb_addr] <= bus.wb_data;
                end
            end
        end
    endgenerate

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = (state_r == FULL);
    assign bus.inst_reg  = inst_r;
    assign bus.ALU_I1    = alu_i1_r;
    assign bus.ALU_I2    = alu_i2_r;
    assign bus.shift     = shift_r;
    assign bus.illegal   = illegal_r;
endmodule
